// File: rtl/ctrl_wb_resolve_pkg.sv
// ctrl_wb_resolve_pkg: shared pipeline packet types, redirect FSM encoding and seqNo age compare.
// Rev 1.0
`default_nettype none

`ifndef SIZE_SEQ
`define SIZE_SEQ 8
`endif

package ctrl_wb_resolve_pkg;

  localparam int SIZE_PC           = 32;
  localparam int SIZE_DATA         = 32;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int SIZE_CTI_LOG      = 4;
  localparam int SIZE_SEQ          = `SIZE_SEQ;

  typedef struct packed {
    logic mispredict;
    logic destValid;
  } wb_flags_t;

  typedef struct packed {
    logic [SIZE_SEQ-1:0]          seqNo;
    logic [SIZE_PC-1:0]           pc;
    logic [SIZE_PC-1:0]           nextPC;
    logic [SIZE_CTI_LOG-1:0]      ctiID;
    logic [SIZE_PHYSICAL_LOG-1:0] phyDest;
    logic [SIZE_DATA-1:0]         destData;
    wb_flags_t                    flags;
    logic                         valid;
  } wbPkt;

  typedef struct packed {
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
    logic [SIZE_DATA-1:0]         data;
    logic                         valid;
  } bypassPkt;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_e;

  // a is older than b when the w-bit modular difference a-b has its MSB set.
  function automatic logic seq_older(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned w);
    return (((a - b) >> (w - 1)) & 32'd1) != 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_redirect_arb.sv
// ctrl_redirect_arb: holds the oldest pending mispredict redirect until fetch accepts it.
// Rev 1.0 -- load_o exists only when CTRL_WB_STATS_EN is defined.
`default_nettype none

module ctrl_redirect_arb
  import ctrl_wb_resolve_pkg::*;
#(
  parameter int SEQ_W = SIZE_SEQ
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    recover_i,
  input  logic                    ready_i,
  input  logic                    cand_i,
  input  logic [SIZE_PC-1:0]      cand_pc_i,
  input  logic [SIZE_CTI_LOG-1:0] cand_cti_i,
  input  logic [SEQ_W-1:0]        cand_seq_i,
  output logic                    valid_o,
  output logic [SIZE_PC-1:0]      pc_o,
  output logic [SIZE_CTI_LOG-1:0] cti_o,
  output logic [SEQ_W-1:0]        seq_o
`ifdef CTRL_WB_STATS_EN
  ,
  output logic                    load_o
`endif
);

  rd_state_e               state_q, state_d;
  logic [SIZE_PC-1:0]      pc_q, pc_d;
  logic [SIZE_CTI_LOG-1:0] cti_q, cti_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic                    load;
  logic                    cand_older;

  assign cand_older = seq_older(32'(cand_seq_i), 32'(seq_q), SEQ_W);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (!recover_i && cand_i) begin
          load    = 1'b1;
          state_d = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (recover_i) begin
          state_d = RD_IDLE;
        end else if (ready_i) begin
          if (cand_i) load = 1'b1;
          else        state_d = RD_IDLE;
        end else if (cand_i && cand_older) begin
          load = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    pc_d  = load ? cand_pc_i  : pc_q;
    cti_d = load ? cand_cti_i : cti_q;
    seq_d = load ? cand_seq_i : seq_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RD_IDLE;
      pc_q    <= '0;
      cti_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cti_q   <= cti_d;
      seq_q   <= seq_d;
    end
  end

  assign valid_o = (state_q == RD_HOLD);
  assign pc_o    = pc_q;
  assign cti_o   = cti_q;
  assign seq_o   = seq_q;
`ifdef CTRL_WB_STATS_EN
  assign load_o  = load;
`endif

endmodule

`default_nettype wire

// File: rtl/ctrl_wb_resolve.sv
// ctrl_wb_resolve: control-pipe writeback register, bypass drive and mispredict redirect hold.
// Rev 1.0 -- define CTRL_WB_STATS_EN to add saturating mispredict/stall counters.
`default_nettype none

module ctrl_wb_resolve
  import ctrl_wb_resolve_pkg::*;
#(
  parameter int SEQ_W = SIZE_SEQ
`ifdef CTRL_WB_STATS_EN
  ,
  parameter int STAT_CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  wbPkt                    wbPacket_i,
  input  logic                    recoverFlag_i,
  input  logic                    redirectReady_i,
  output bypassPkt                bypassPacket_o,
  output wbPkt                    ctrlWbPacket_o,
  output logic                    redirectValid_o,
  output logic [SIZE_PC-1:0]      redirectPC_o,
  output logic [SIZE_CTI_LOG-1:0] redirectCtiID_o,
  output logic [SEQ_W-1:0]        redirectSeqNo_o
`ifdef CTRL_WB_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0]   mispredCnt_o,
  output logic [STAT_CNT_W-1:0]   redirStallCnt_o
`endif
);

  wbPkt wb_d, wb_q;
  logic cand;

  // A packet captured during recovery is kept but marked invalid.
  always_comb begin
    wb_d       = wbPacket_i;
    wb_d.valid = wbPacket_i.valid & ~recoverFlag_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) wb_q <= '0;
    else          wb_q <= wb_d;
  end

  assign ctrlWbPacket_o       = wb_q;
  assign bypassPacket_o.tag   = wb_q.phyDest;
  assign bypassPacket_o.data  = wb_q.destData;
  assign bypassPacket_o.valid = wb_q.valid & wb_q.flags.destValid;
  assign cand                 = wb_q.valid & wb_q.flags.mispredict;

`ifdef CTRL_WB_STATS_EN
  logic captured;
`endif

  ctrl_redirect_arb #(
    .SEQ_W (SEQ_W)
  ) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .recover_i  (recoverFlag_i),
    .ready_i    (redirectReady_i),
    .cand_i     (cand),
    .cand_pc_i  (wb_q.nextPC),
    .cand_cti_i (wb_q.ctiID),
    .cand_seq_i (SEQ_W'(wb_q.seqNo)),
    .valid_o    (redirectValid_o),
    .pc_o       (redirectPC_o),
    .cti_o      (redirectCtiID_o),
    .seq_o      (redirectSeqNo_o)
`ifdef CTRL_WB_STATS_EN
    ,
    .load_o     (captured)
`endif
  );

`ifdef CTRL_WB_STATS_EN
  localparam logic [STAT_CNT_W-1:0] CNT_MAX = '1;

  logic [STAT_CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [STAT_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counters survive recovery; only reset clears them.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (captured && (mispred_cnt_q != CNT_MAX))
      mispred_cnt_d = mispred_cnt_q + STAT_CNT_W'(1);
    if (redirectValid_o && !redirectReady_i && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + STAT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mispred_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mispredCnt_o    = mispred_cnt_q;
  assign redirStallCnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_wb_resolve.sv
// tb_ctrl_wb_resolve: directed vector table, corner sequences and random traffic against a queue-based model.
// Rev 1.0 -- counter checks are active when CTRL_WB_STATS_EN is defined.
`default_nettype none

module tb_ctrl_wb_resolve;
  import ctrl_wb_resolve_pkg::*;

  localparam int SW = SIZE_SEQ;

  logic                    clk = 1'b0;
  logic                    reset_n;
  wbPkt                    wb_in;
  logic                    recover;
  logic                    ready;
  bypassPkt                byp;
  wbPkt                    ctrl_out;
  logic                    rv;
  logic [SIZE_PC-1:0]      rpc;
  logic [SIZE_CTI_LOG-1:0] rcti;
  logic [SW-1:0]           rseq;
`ifdef CTRL_WB_STATS_EN
  logic [15:0]             mis_cnt;
  logic [15:0]             stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_wb_resolve dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wbPacket_i      (wb_in),
    .recoverFlag_i   (recover),
    .redirectReady_i (ready),
    .bypassPacket_o  (byp),
    .ctrlWbPacket_o  (ctrl_out),
    .redirectValid_o (rv),
    .redirectPC_o    (rpc),
    .redirectCtiID_o (rcti),
    .redirectSeqNo_o (rseq)
`ifdef CTRL_WB_STATS_EN
    ,
    .mispredCnt_o    (mis_cnt),
    .redirStallCnt_o (stall_cnt)
`endif
  );

  // Reference model: registered packet plus a 0/1-entry queue of pending redirects.
  wbPkt m_reg;
  wbPkt m_held[$];
  int   m_mis;
  int   m_stall;

  function automatic wbPkt mk(input logic [31:0] pc, input logic [31:0] npc,
                              input logic [SW-1:0] seq, input logic [3:0] cti,
                              input logic [6:0] dest, input logic [31:0] data,
                              input logic dv, input logic mp, input logic v);
    wbPkt p;
    p.seqNo = seq; p.pc = pc; p.nextPC = npc; p.ctiID = cti;
    p.phyDest = dest; p.destData = data;
    p.flags.destValid = dv; p.flags.mispredict = mp; p.valid = v;
    return p;
  endfunction

  function automatic bit m_older(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int d;
    d = (int'(a) - int'(b) + (1 << SW)) % (1 << SW);
    return d >= (1 << (SW - 1));
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input wbPkt p, input logic rec, input logic rdy, input logic rstn);
    bit cand;
    if (!rstn) begin
      m_reg = '0; m_held.delete(); m_mis = 0; m_stall = 0;
      return;
    end
    cand = m_reg.valid && m_reg.flags.mispredict;
    if (m_held.size() != 0 && !rdy && m_stall < 65535) m_stall++;
    if (rec) begin
      m_held.delete();
    end else if (m_held.size() == 0 || rdy) begin
      m_held.delete();
      if (cand) begin
        m_held.push_back(m_reg);
        if (m_mis < 65535) m_mis++;
      end
    end else if (cand && m_older(m_reg.seqNo, m_held[0].seqNo)) begin
      m_held[0] = m_reg;
      if (m_mis < 65535) m_mis++;
    end
    m_reg = p;
    if (rec) m_reg.valid = 1'b0;
  endtask

  task automatic compare_model();
    bypassPkt eb;
    eb.tag   = m_reg.phyDest;
    eb.data  = m_reg.destData;
    eb.valid = m_reg.valid && m_reg.flags.destValid;
    check("ctrl_pkt", 128'(ctrl_out), 128'(m_reg));
    check("bypass", 128'(byp), 128'(eb));
    check("redir_valid", 128'(rv), 128'(m_held.size() != 0));
    if (m_held.size() != 0) begin
      check("redir_pc", 128'(rpc), 128'(m_held[0].nextPC));
      check("redir_cti", 128'(rcti), 128'(m_held[0].ctiID));
      check("redir_seq", 128'(rseq), 128'(m_held[0].seqNo));
    end
`ifdef CTRL_WB_STATS_EN
    check("mispred_cnt", 128'(mis_cnt), 128'(m_mis));
    check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
  endtask

  task automatic step(input wbPkt p, input logic rec, input logic rdy, input logic rstn);
    wb_in = p; recover = rec; ready = rdy; reset_n = rstn;
    @(posedge clk);
    model_edge(p, rec, rdy, rstn);
    #1;
    compare_model();
  endtask

  typedef struct {
    wbPkt        pkt;
    logic        rec;
    logic        rdy;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [7:0]  e_rseq;
    logic        e_byp_v;
    logic [6:0]  e_tag;
    logic [31:0] e_data;
    logic        e_ctrl_v;
    logic [31:0] e_ctrl_pc;
    int          e_mis;
    int          e_stall;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wbPkt idle, p0, pa, pb, pc, pd, pe, pf, pg, ph, pr;

    idle = '0;
    p0 = mk(32'h100, 32'h104,   0, 4'd0, 7'd5, 32'hAB, 1'b1, 1'b0, 1'b1);
    pa = mk(32'h104, 32'h200,  10, 4'd1, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);
    pb = mk(32'h108, 32'h300,  10, 4'd2, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);
    pc = mk(32'h10C, 32'h400,   7, 4'd3, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);
    pd = mk(32'h110, 32'h500,  12, 4'd4, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);
    pe = mk(32'h114, 32'h600,   1, 4'd5, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);
    pf = mk(32'h118, 32'h700,   3, 4'd6, 7'd9, 32'h55, 1'b1, 1'b1, 1'b1);
    pg = mk(32'h120, 32'h800,   2, 4'd7, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);
    ph = mk(32'h124, 32'h900, 254, 4'd8, 7'd0, 32'h0,  1'b0, 1'b1, 1'b1);

    //            pkt   rec   rdy   rv    rpc        rseq byp_v tag  data     ctrl_v ctrl_pc  mis stall
    tbl[0]  = '{p0,   1'b0, 1'b0, 1'b0, 32'h0,   8'd0,  1'b1, 7'd5, 32'hAB, 1'b1, 32'h100, 0, 0};
    tbl[1]  = '{pa,   1'b0, 1'b0, 1'b0, 32'h0,   8'd0,  1'b0, 7'd0, 32'h0,  1'b1, 32'h104, 0, 0};
    tbl[2]  = '{idle, 1'b0, 1'b0, 1'b1, 32'h200, 8'd10, 1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   1, 0};
    tbl[3]  = '{idle, 1'b0, 1'b0, 1'b1, 32'h200, 8'd10, 1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   1, 1};
    tbl[4]  = '{idle, 1'b0, 1'b0, 1'b1, 32'h200, 8'd10, 1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   1, 2};
    tbl[5]  = '{idle, 1'b0, 1'b0, 1'b1, 32'h200, 8'd10, 1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   1, 3};
    tbl[6]  = '{idle, 1'b0, 1'b1, 1'b0, 32'h0,   8'd0,  1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   1, 3};
    tbl[7]  = '{pb,   1'b0, 1'b0, 1'b0, 32'h0,   8'd0,  1'b0, 7'd0, 32'h0,  1'b1, 32'h108, 1, 3};
    tbl[8]  = '{pc,   1'b0, 1'b0, 1'b1, 32'h300, 8'd10, 1'b0, 7'd0, 32'h0,  1'b1, 32'h10C, 2, 3};
    tbl[9]  = '{pd,   1'b0, 1'b0, 1'b1, 32'h400, 8'd7,  1'b0, 7'd0, 32'h0,  1'b1, 32'h110, 3, 4};
    tbl[10] = '{idle, 1'b0, 1'b0, 1'b1, 32'h400, 8'd7,  1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   3, 5};
    tbl[11] = '{pe,   1'b0, 1'b0, 1'b1, 32'h400, 8'd7,  1'b0, 7'd0, 32'h0,  1'b1, 32'h114, 3, 6};
    tbl[12] = '{pf,   1'b1, 1'b0, 1'b0, 32'h0,   8'd0,  1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   3, 7};
    tbl[13] = '{idle, 1'b0, 1'b0, 1'b0, 32'h0,   8'd0,  1'b0, 7'd0, 32'h0,  1'b0, 32'h0,   3, 7};

    // Reset held for two cycles with live traffic on the inputs.
    step(pf, 1'b0, 1'b0, 1'b0);
    step(pa, 1'b0, 1'b0, 1'b0);
    check("reset_redir_valid", 128'(rv), 128'(0));
    check("reset_ctrl_pkt", 128'(ctrl_out), 128'(0));
    check("reset_bypass", 128'(byp), 128'(0));
    check("reset_redir_pc", 128'(rpc), 128'(0));

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].pkt, tbl[i].rec, tbl[i].rdy, 1'b1);
      check($sformatf("vec%0d_redir_valid", i), 128'(rv), 128'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        check($sformatf("vec%0d_redir_pc", i), 128'(rpc), 128'(tbl[i].e_rpc));
        check($sformatf("vec%0d_redir_seq", i), 128'(rseq), 128'(tbl[i].e_rseq));
      end
      check($sformatf("vec%0d_byp_valid", i), 128'(byp.valid), 128'(tbl[i].e_byp_v));
      if (tbl[i].e_byp_v) begin
        check($sformatf("vec%0d_byp_tag", i), 128'(byp.tag), 128'(tbl[i].e_tag));
        check($sformatf("vec%0d_byp_data", i), 128'(byp.data), 128'(tbl[i].e_data));
      end
      check($sformatf("vec%0d_ctrl_valid", i), 128'(ctrl_out.valid), 128'(tbl[i].e_ctrl_v));
      if (tbl[i].e_ctrl_v)
        check($sformatf("vec%0d_ctrl_pc", i), 128'(ctrl_out.pc), 128'(tbl[i].e_ctrl_pc));
`ifdef CTRL_WB_STATS_EN
      check($sformatf("vec%0d_mispred_cnt", i), 128'(mis_cnt), 128'(tbl[i].e_mis));
      check($sformatf("vec%0d_stall_cnt", i), 128'(stall_cnt), 128'(tbl[i].e_stall));
`endif
    end

    // Sequence-number wrap: 254 is older than a held 2.
    step(pg, 1'b0, 1'b0, 1'b1);
    step(ph, 1'b0, 1'b0, 1'b1);
    check("wrap_held_seq", 128'(rseq), 128'(2));
    step(idle, 1'b0, 1'b0, 1'b1);
    check("wrap_replaced_seq", 128'(rseq), 128'(254));
    check("wrap_replaced_pc", 128'(rpc), 128'(32'h900));
    step(idle, 1'b0, 1'b1, 1'b1);
    check("wrap_accept_drop", 128'(rv), 128'(0));

    // Reset in the middle of a held redirect drops it without acceptance.
    step(pg, 1'b0, 1'b0, 1'b1);
    step(idle, 1'b0, 1'b0, 1'b1);
    check("midreset_pending", 128'(rv), 128'(1));
    step(idle, 1'b0, 1'b0, 1'b0);
    check("midreset_dropped", 128'(rv), 128'(0));
    step(idle, 1'b0, 1'b1, 1'b1);
    check("midreset_stays_idle", 128'(rv), 128'(0));

    for (int n = 0; n < 800; n++) begin
      pr = mk($urandom, $urandom, SW'($urandom), 4'($urandom), 7'($urandom), $urandom,
              1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      step(pr, ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 49) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
